multi_cycle_sequencer: RTL

//  Parametrised stage sequencer for the multi-cycle CPU. Generalises the fixed IDLE/IF/ID/EXE/MEM/WB controller to NSTAGE stages.

---
 rtl/multi_cycle_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/multi_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// multi_cycle_sequencer: one-hot stage sequencer with skip, halt, watchdog
// Revision: 1.0
// ============================================================================
module multi_cycle_sequencer #(
  parameter int NSTAGE  = 5,
  parameter int BUS_W   = 150,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NSTAGE-1:0]             stage_over,
  input  logic                          skip_req,
  input  logic                          halt_req,
  input  logic                          err_clr,
  input  logic [(NSTAGE-1)*BUS_W-1:0]   bus_in,
  output logic [(NSTAGE-1)*BUS_W-1:0]   bus_r,
  output logic [NSTAGE-1:0]             stage_valid,
  output logic                          next_first,
  output logic [CNT_W-1:0]              retire_cnt,
  output logic [CNT_W-1:0]              cycle_cnt,
  output logic                          timeout_err,
  output logic [7:0]                    err_stage,
  output logic [31:0]                   display_state
);

  localparam int IDX_W = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSTAGE - 1);
  localparam logic [31:0]      HALT_CODE = 32'(NSTAGE + 1);

  // The visible state code is phase plus stage index: IDLE=0, S_k=k+1, HALT=NSTAGE+1.
  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_RUN  = 2'd1,
    PH_HALT = 2'd2
  } phase_t;

  phase_t           phase;
  phase_t           phase_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [WD_W-1:0]  wd;
  logic             in_run;
  logic             cur_over;
  logic             retire;
  logic             expire;
  logic [31:0]      code_nxt;

  always_comb begin
    in_run   = (phase == PH_RUN);
    cur_over = stage_over[idx];
    retire   = in_run && cur_over && (skip_req || (idx == LAST_IDX));
    expire   = in_run && !cur_over && (TIMEOUT != 0) && (wd == WD_LAST);
  end

  assign next_first = retire;

  always_comb begin
    phase_nxt = phase;
    idx_nxt   = idx;
    case (phase)
      PH_IDLE: begin
        phase_nxt = halt_req ? PH_HALT : PH_RUN;
        idx_nxt   = '0;
      end
      PH_RUN: begin
        if (retire) begin
          phase_nxt = halt_req ? PH_HALT : PH_RUN;
          idx_nxt   = '0;
        end else if (cur_over) begin
          idx_nxt = idx + IDX_W'(1);
        end else if (expire) begin
          phase_nxt = PH_HALT;
        end
      end
      PH_HALT: begin
        // Exit only once the registered error has been cleared.
        if (!halt_req && !timeout_err) begin
          phase_nxt = PH_RUN;
          idx_nxt   = '0;
        end
      end
      default: begin
        phase_nxt = PH_IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    code_nxt = 32'd0;
    if (phase_nxt == PH_RUN) begin
      code_nxt = 32'(idx_nxt) + 32'd1;
    end else if (phase_nxt == PH_HALT) begin
      code_nxt = HALT_CODE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase         <= PH_IDLE;
      idx           <= '0;
      wd            <= '0;
      stage_valid   <= '0;
      display_state <= 32'd0;
      retire_cnt    <= '0;
      cycle_cnt     <= '0;
      timeout_err   <= 1'b0;
      err_stage     <= 8'd0;
    end else begin
      phase         <= phase_nxt;
      idx           <= idx_nxt;
      display_state <= code_nxt;
      stage_valid   <= (phase_nxt == PH_RUN) ?
                       ({{(NSTAGE-1){1'b0}}, 1'b1} << idx_nxt) : '0;
      // Watchdog counts only while the current stage is waiting.
      if (in_run && !cur_over && !expire) begin
        wd <= wd + WD_W'(1);
      end else begin
        wd <= '0;
      end
      if (retire) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
      if (in_run) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      if (expire) begin
        timeout_err <= 1'b1;
        err_stage   <= 8'(idx);
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NSTAGE - 1; k++) begin : g_bus
    logic [BUS_W-1:0] q;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        q <= '0;
      end else if (in_run && cur_over && (idx == IDX_W'(k))) begin
        q <= bus_in[k*BUS_W +: BUS_W];
      end
    end

    assign bus_r[k*BUS_W +: BUS_W] = q;
  end

endmodule
`default_nettype wire
